// File: rtl/ks_loop_filter.sv
// Karplus-Strong loop filter: two-tap average of delay-line samples scaled by a Q1.16 decay gain.
// Latency: fixed 3 edges after the capturing edge (filter and bypass alike), one sample per clock.
// Backpressure: none; the pipeline never stalls and samples in flight always complete.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   in_valid  din carries a new delay-line sample
//   din       signed sample from the delay line
//   decay     unsigned Q1.16 gain, values above 1.0 clamp to 1.0
//   trig      pluck strobe, clears the history sample (wins over in_valid)
//   bypass    pass din through unfiltered with the same latency
//   out_valid dout carries a new feedback sample
//   dout      signed feedback sample, holds its value while out_valid=0
//
// Build option: define KS_LOOP_FILTER_ROUND_EN to round half up in the Q16 rescale;
// without it the rescale truncates toward negative infinity.

module ks_loop_filter #(
  parameter int DATA_W  = 32,
  parameter int DECAY_W = 17
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  din,
  input  logic        [DECAY_W-1:0] decay,
  input  logic                      trig,
  input  logic                      bypass,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  dout
);

  localparam int FRAC   = 16;
  // Product of a DATA_W signed average and a zero-extended unsigned gain.
  localparam int PROD_W = DATA_W + DECAY_W + 1;
  // One guard bit so the rounding add cannot overflow.
  localparam int SH_W   = PROD_W + 1;

  localparam logic [DECAY_W-1:0]       DECAY_ONE = DECAY_W'(1) << FRAC;
  localparam logic signed [SH_W-1:0]   MAXV      = SH_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [SH_W-1:0]   MINV      = ~MAXV;

  // History
  logic signed [DATA_W-1:0]  r_xprev;

  // S1
  logic                      r_vld1;
  logic signed [DATA_W:0]    r_sum1;
  logic signed [DATA_W-1:0]  r_din1;
  logic        [DECAY_W-1:0] r_decay1;
  logic                      r_byp1;

  // S2
  logic                      r_vld2;
  logic signed [PROD_W-1:0]  r_prod2;
  logic signed [DATA_W-1:0]  r_din2;
  logic                      r_byp2;

  // S3
  logic                      r_vld3;
  logic signed [DATA_W-1:0]  r_res3;

  // Output register
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_dout;

  // Combinational datapath
  logic signed [DATA_W:0]    w_sum;
  logic        [DECAY_W-1:0] w_decay_c;
  logic signed [DATA_W:0]    w_sum_sh;
  logic signed [PROD_W-1:0]  w_avg_ext;
  logic signed [PROD_W-1:0]  w_dec_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SH_W-1:0]    w_prod_ext;
  logic signed [SH_W-1:0]    w_scaled;
  logic signed [DATA_W-1:0]  w_clamped;

  // One extra bit makes the two-sample sum exact.
  assign w_sum     = {din[DATA_W-1], din} + {r_xprev[DATA_W-1], r_xprev};
  assign w_decay_c = (decay > DECAY_ONE) ? DECAY_ONE : decay;

  // Floor-halve the sum; the shifted value still fits DATA_W signed bits,
  // so sign-extending the full shifted word keeps the product exact.
  assign w_sum_sh  = r_sum1 >>> 1;
  assign w_avg_ext = {{(PROD_W-DATA_W-1){w_sum_sh[DATA_W]}}, w_sum_sh};
  assign w_dec_ext = {{(PROD_W-DECAY_W){1'b0}}, r_decay1};
  assign w_prod    = w_avg_ext * w_dec_ext;

`ifdef KS_LOOP_FILTER_ROUND_EN
  localparam logic [SH_W-1:0] RND = SH_W'(1) << (FRAC-1);
  assign w_prod_ext = {r_prod2[PROD_W-1], r_prod2} + RND;
`else
  assign w_prod_ext = {r_prod2[PROD_W-1], r_prod2};
`endif

  assign w_scaled = w_prod_ext >>> FRAC;

  // With the gain capped at 1.0 the result is always in range; the clamp is
  // a guard against any future widening of the gain.
  always_comb begin
    w_clamped = w_scaled[DATA_W-1:0];
    if (w_scaled > MAXV) begin
      w_clamped = MAXV[DATA_W-1:0];
    end else if (w_scaled < MINV) begin
      w_clamped = MINV[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xprev     <= '0;
      r_vld1      <= 1'b0;
      r_sum1      <= '0;
      r_din1      <= '0;
      r_decay1    <= '0;
      r_byp1      <= 1'b0;
      r_vld2      <= 1'b0;
      r_prod2     <= '0;
      r_din2      <= '0;
      r_byp2      <= 1'b0;
      r_vld3      <= 1'b0;
      r_res3      <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else begin
      // A pluck clears history even when it coincides with a sample; that
      // sample has already used the old history in w_sum.
      if (trig) begin
        r_xprev <= '0;
      end else if (in_valid) begin
        r_xprev <= din;
      end

      r_vld1 <= in_valid;
      if (in_valid) begin
        r_sum1   <= w_sum;
        r_din1   <= din;
        r_decay1 <= w_decay_c;
        r_byp1   <= bypass;
      end

      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_prod2 <= w_prod;
        r_din2  <= r_din1;
        r_byp2  <= r_byp1;
      end

      r_vld3 <= r_vld2;
      if (r_vld2) begin
        r_res3 <= r_byp2 ? r_din2 : w_clamped;
      end

      r_out_valid <= r_vld3;
      if (r_vld3) begin
        r_dout <= r_res3;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule

// File: tb/tb_ks_loop_filter.sv
module tb_ks_loop_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] din;
  logic [16:0]        decay;
  logic               trig;
  logic               bypass;
  logic               out_valid;
  logic signed [31:0] dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ks_loop_filter #(.DATA_W(32), .DECAY_W(17)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .din       (din),
    .decay     (decay),
    .trig      (trig),
    .bypass    (bypass),
    .out_valid (out_valid),
    .dout      (dout)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint x, input longint m);
    if (x >= 0) return x / m;
    return -((-x + m - 1) / m);
  endfunction

  // Reference: what the feedback sample must be for one accepted input.
  function automatic longint calc(input longint d, input longint xp_i,
                                  input longint dec, input bit byp);
    longint a, g, p, s;
    if (byp) return d;
    a = fdiv(d + xp_i, 2);
    g = (dec > 65536) ? 65536 : dec;
    p = a * g;
`ifdef KS_LOOP_FILTER_ROUND_EN
    s = fdiv(p + 32768, 65536);
`else
    s = fdiv(p, 65536);
`endif
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  // Behavioural model: history value plus a queue of results with due edges.
  int                 cyc = 0;
  longint             xp = 0;
  int                 q_due[$];
  longint             q_val[$];
  logic               m_vld = 1'b0;
  logic signed [31:0] m_dout = '0;
  int                 lit_due[$];
  longint             lit_val[$];
  string              lit_name[$];

  always @(posedge clk) begin
    longint v;
    cyc++;
    if (reset) begin
      xp = 0;
      q_due.delete();
      q_val.delete();
      m_vld = 1'b0;
      m_dout = '0;
    end else begin
      m_vld = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        v = q_val[0];
        m_vld = 1'b1;
        m_dout = v[31:0];
        void'(q_due.pop_front());
        void'(q_val.pop_front());
      end
      if (in_valid) begin
        q_due.push_back(cyc + 3);
        q_val.push_back(calc(longint'(din), xp, longint'(decay), bypass));
      end
      if (trig) xp = 0;
      else if (in_valid) xp = longint'(din);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_dout", longint'(dout), 0);
    end else begin
      chk("out_valid", longint'(out_valid), longint'(m_vld));
      chk("dout", longint'(dout), longint'(m_dout));
    end
    while (lit_due.size() > 0 && lit_due[0] < cyc) begin
      chk({lit_name[0], "_missed"}, 0, 1);
      void'(lit_due.pop_front());
      void'(lit_val.pop_front());
      void'(lit_name.pop_front());
    end
    if (lit_due.size() > 0 && lit_due[0] == cyc) begin
      chk({lit_name[0], "_vld"}, longint'(out_valid), 1);
      chk(lit_name[0], longint'(dout), lit_val[0]);
      void'(lit_due.pop_front());
      void'(lit_val.pop_front());
      void'(lit_name.pop_front());
    end
  end

  // Present inputs for the next edge, optionally expect a literal result,
  // then move to just after that edge.
  task automatic drv(input logic v, input logic [31:0] d, input int dec,
                     input logic t, input logic b,
                     input string lname, input longint lit);
    in_valid = v;
    din      = d;
    decay    = dec[16:0];
    trig     = t;
    bypass   = b;
    if (lname != "") begin
      lit_due.push_back(cyc + 4);
      lit_val.push_back(lit);
      lit_name.push_back(lname);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(1'b0, 32'd0, 65536, 1'b0, 1'b0, "", 0);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    lit_due.delete();
    lit_val.delete();
    lit_name.delete();
    #1;
    chk("midrst_out_valid_now", longint'(out_valid), 0);
    chk("midrst_dout_now", longint'(dout), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    decay    = 17'h10000;
    trig     = 1'b0;
    bypass   = 1'b0;

    // Pin the reference model against hand-computed values.
    chk("pin_avg_500", calc(1000, 0, 65536, 0), 500);
    chk("pin_avg_1500", calc(2000, 1000, 65536, 0), 1500);
    chk("pin_half_gain", calc(4000, 0, 32768, 0), 1000);
    chk("pin_neg3", calc(-3, 0, 65536, 0), -2);
`ifdef KS_LOOP_FILTER_ROUND_EN
    chk("pin_neg1_half", calc(-1, 0, 32768, 0), 0);
`else
    chk("pin_neg1_half", calc(-1, 0, 32768, 0), -1);
`endif
    chk("pin_max_clampgain", calc(2147483647, 2147483647, 131071, 0), 2147483647);
    chk("pin_trig_avg", calc(100, 5000, 65536, 0), 2550);
    chk("pin_bypass", calc(5, 7, 0, 1), 5);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_vld", longint'(out_valid), 0);
    chk("reset_state_dout", longint'(dout), 0);
    reset = 1'b0;

    // First sample accepted on the first edge after release.
    drv(1, 32'd1000, 65536, 0, 0, "first_500", 500);
    drv(1, 32'd2000, 65536, 0, 0, "second_1500", 1500);
    idle(4);

    // Half gain from a cleared history.
    drv(0, 32'd0, 65536, 1, 0, "", 0);
    drv(1, 32'd4000, 32768, 0, 0, "half_1000", 1000);
    drv(1, 32'd4000, 32768, 0, 0, "half_2000", 2000);
    idle(3);

    // Negative floor halving and rounding of a half-LSB product.
    drv(0, 32'd0, 65536, 1, 0, "", 0);
    drv(1, -32'sd3, 65536, 0, 0, "neg3_avg", -2);
    drv(0, 32'd0, 65536, 1, 0, "", 0);
`ifdef KS_LOOP_FILTER_ROUND_EN
    drv(1, -32'sd1, 32768, 0, 0, "neg1_round", 0);
`else
    drv(1, -32'sd1, 32768, 0, 0, "neg1_trunc", -1);
`endif
    idle(3);

    // Full-scale input with an over-range gain: no wrap.
    drv(0, 32'd0, 65536, 1, 0, "", 0);
    drv(1, 32'h7FFFFFFF, 17'h1FFFF, 0, 0, "max_first", 32'h3FFFFFFF);
    drv(1, 32'h7FFFFFFF, 17'h1FFFF, 0, 0, "max_second", 32'h7FFFFFFF);
    idle(3);

    // Pluck coinciding with a sample uses the old history, then zero.
    drv(1, 32'd5000, 65536, 0, 0, "", 0);
    drv(1, 32'd100, 65536, 1, 0, "trig_2550", 2550);
    drv(1, 32'd200, 65536, 0, 0, "after_trig_100", 100);
    idle(3);

    // Bypass with the same latency, then reset in the middle of a stream.
    drv(1, 32'h12345678, 65536, 0, 1, "bypass", 32'h12345678);
    idle(4);
    drv(1, 32'd111, 65536, 0, 0, "", 0);
    drv(1, 32'd222, 65536, 0, 0, "", 0);
    mid_reset();
    idle(6);

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      int          dec;
      int          r;
      r = $urandom_range(0, 9);
      if (r == 0)      d = 32'h7FFFFFFF;
      else if (r == 1) d = 32'h80000000;
      else             d = $urandom;
      r = $urandom_range(0, 5);
      if (r == 0)      dec = 65536 + $urandom_range(1, 65535);
      else if (r == 1) dec = 65536;
      else             dec = $urandom_range(0, 65536);
      drv(($urandom_range(0, 3) != 0), d, dec,
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), "", 0);
      if (i % 700 == 350) mid_reset();
    end
    idle(6);

    chk("literal_queue_drained", longint'(lit_due.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
